tutankham_input_conditioner: RTL and testbench

//  Sits directly upstream of the Tutankham top level and produces its coin, start_buttons,

---
 rtl/tutankham_input_conditioner.sv | 269 ++++++++++++++++++++++++++
 tb/tb_tutankham_input_conditioner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tutankham_input_conditioner.sv
// Host-input conditioner for the Tutankham core: synchronises and debounces raw buttons,
// shapes coin presses into fixed credit pulses and cleans up both joysticks.
module tutankham_input_conditioner #(
  parameter int TICK_DIV    = 49152,
  parameter int DEBOUNCE_MS = 5,
  parameter int COIN_MIN_MS = 50,
  parameter int COIN_GAP_MS = 50,
  parameter bit FOURWAY     = 1'b1
) (
  input  logic       clk_49m,
  input  logic       reset,
  input  logic       pause,
  input  logic [1:0] raw_coin,
  input  logic [1:0] raw_start,
  input  logic [3:0] raw_p1_joy,
  input  logic [3:0] raw_p2_joy,
  input  logic       raw_p1_fire,
  input  logic       raw_p2_fire,
  input  logic       raw_service,
  output logic [1:0] coin,
  output logic [1:0] start_buttons,
  output logic [3:0] left_joystick,
  output logic [3:0] right_joystick,
  output logic       p1_fire,
  output logic       p2_fire,
  output logic       btn_service
);

  localparam int NSYNC = 16;
  localparam int NDB   = 15;
  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW    = $clog2(DEBOUNCE_MS + 1);
  localparam int CMAX  = (COIN_MIN_MS > COIN_GAP_MS) ? COIN_MIN_MS : COIN_GAP_MS;
  localparam int TW    = $clog2(CMAX + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_MS - 1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(COIN_MIN_MS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(COIN_GAP_MS - 1);

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_PULSE = 2'd1,
    C_GAP   = 2'd2
  } coin_state_t;

  function automatic logic [3:0] cancel_opposing(input logic [3:0] d);
    logic [3:0] c;
    c = d;
    if (d[0] && d[1]) begin
      c[1:0] = 2'b00;
    end else begin
      c[1:0] = d[1:0];
    end
    if (d[2] && d[3]) begin
      c[3:2] = 2'b00;
    end else begin
      c[3:2] = d[3:2];
    end
    return c;
  endfunction

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0]) begin
      idx = 2'd0;
    end else if (v[1]) begin
      idx = 2'd1;
    end else if (v[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic more_than_one(input logic [3:0] v);
    return |(v & (v - 4'd1));
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Bit map: coin[1:0], start[3:2], p1 joy[7:4], p2 joy[11:8], p1 fire 12, p2 fire 13,
  // service 14, pause 15 (pause is synchronised but not debounced).
  logic [NSYNC-1:0] raw_s;
  logic [NSYNC-1:0] sync1_q;
  logic [NSYNC-1:0] sync2_q;
  logic             pause_s;

  assign raw_s   = {pause, raw_service, raw_p2_fire, raw_p1_fire,
                    raw_p2_joy, raw_p1_joy, raw_start, raw_coin};
  assign pause_s = sync2_q[15];

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      sync1_q <= {NSYNC{1'b0}};
      sync2_q <= {NSYNC{1'b0}};
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  logic [PW-1:0] presc_q;
  logic          tick_s;

  assign tick_s = (presc_q == PRESC_LAST);

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      presc_q <= {PW{1'b0}};
    end else if (tick_s) begin
      presc_q <= {PW{1'b0}};
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  logic [NDB-1:0] db_q;
  logic [NDB-1:0] db_d;
  logic [DW-1:0]  dcnt_q [NDB];
  logic [DW-1:0]  dcnt_d [NDB];

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NDB; i++) begin
      dcnt_d[i] = dcnt_q[i];
      if (tick_s) begin
        if (sync2_q[i] != db_q[i]) begin
          if (dcnt_q[i] == DEB_LAST) begin
            db_d[i]   = ~db_q[i];
            dcnt_d[i] = {DW{1'b0}};
          end else begin
            dcnt_d[i] = dcnt_q[i] + DW'(1);
          end
        end else begin
          dcnt_d[i] = {DW{1'b0}};
        end
      end else begin
        dcnt_d[i] = dcnt_q[i];
      end
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      db_q <= {NDB{1'b0}};
      for (int i = 0; i < NDB; i++) begin
        dcnt_q[i] <= {DW{1'b0}};
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < NDB; i++) begin
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  // IDLE is only ever entered with the debounced coin low, so a high level there is a fresh edge.
  coin_state_t   cst_q  [2];
  logic [TW-1:0] ctmr_q [2];

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      coin <= 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
        cst_q[ch]  <= C_IDLE;
        ctmr_q[ch] <= {TW{1'b0}};
      end
    end else if (tick_s && !pause_s) begin
      for (int ch = 0; ch < 2; ch++) begin
        case (cst_q[ch])
          C_IDLE: begin
            if (db_q[ch]) begin
              cst_q[ch]  <= C_PULSE;
              ctmr_q[ch] <= {TW{1'b0}};
              coin[ch]   <= 1'b1;
            end
          end
          C_PULSE: begin
            if (ctmr_q[ch] == PULSE_LAST) begin
              cst_q[ch]  <= C_GAP;
              ctmr_q[ch] <= {TW{1'b0}};
              coin[ch]   <= 1'b0;
            end else begin
              ctmr_q[ch] <= ctmr_q[ch] + TW'(1);
            end
          end
          C_GAP: begin
            if (ctmr_q[ch] == GAP_LAST) begin
              if (!db_q[ch]) begin
                cst_q[ch]  <= C_IDLE;
                ctmr_q[ch] <= {TW{1'b0}};
              end
            end else begin
              ctmr_q[ch] <= ctmr_q[ch] + TW'(1);
            end
          end
          default: begin
            cst_q[ch]  <= C_IDLE;
            ctmr_q[ch] <= {TW{1'b0}};
            coin[ch]   <= 1'b0;
          end
        endcase
      end
    end
  end

  logic [3:0] jc_s   [2];
  logic [3:0] jrise_s[2];
  logic [3:0] jprev_q[2];
  logic [3:0] jout_d [2];
  logic [1:0] ldir_q [2];
  logic [1:0] ldir_d [2];

  assign jc_s[0]    = cancel_opposing(db_q[7:4]);
  assign jc_s[1]    = cancel_opposing(db_q[11:8]);
  assign jrise_s[0] = jc_s[0] & ~jprev_q[0];
  assign jrise_s[1] = jc_s[1] & ~jprev_q[1];

  // The most recently pressed direction wins while several are held; simultaneous rises favour the lowest index.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      jout_d[p] = jc_s[p];
      if (jrise_s[p] != 4'b0000) begin
        ldir_d[p] = lowest_idx(jrise_s[p]);
      end else begin
        ldir_d[p] = ldir_q[p];
      end
      if (!FOURWAY || !more_than_one(jc_s[p])) begin
        jout_d[p] = jc_s[p];
      end else if (jc_s[p][ldir_d[p]]) begin
        jout_d[p] = onehot(ldir_d[p]);
      end else begin
        ldir_d[p] = lowest_idx(jc_s[p]);
        jout_d[p] = onehot(lowest_idx(jc_s[p]));
      end
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      start_buttons  <= 2'b00;
      left_joystick  <= 4'b0000;
      right_joystick <= 4'b0000;
      p1_fire        <= 1'b0;
      p2_fire        <= 1'b0;
      btn_service    <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        jprev_q[p] <= 4'b0000;
        ldir_q[p]  <= 2'd0;
      end
    end else begin
      start_buttons  <= db_q[3:2];
      left_joystick  <= jout_d[0];
      right_joystick <= jout_d[1];
      p1_fire        <= db_q[12];
      p2_fire        <= db_q[13];
      btn_service    <= db_q[14];
      for (int p = 0; p < 2; p++) begin
        jprev_q[p] <= jc_s[p];
        ldir_q[p]  <= ldir_d[p];
      end
    end
  end

endmodule

// File: tb/tb_tutankham_input_conditioner.sv
// Scoreboard bench for tutankham_input_conditioner: stimulus queues expected output snapshots
// and coin pulse widths, a monitor process compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_tutankham_input_conditioner;

  logic       clk_49m = 1'b0;
  logic       reset;
  logic       pause;
  logic [1:0] raw_coin;
  logic [1:0] raw_start;
  logic [3:0] raw_p1_joy;
  logic [3:0] raw_p2_joy;
  logic       raw_p1_fire;
  logic       raw_p2_fire;
  logic       raw_service;
  logic [1:0] coin;
  logic [1:0] start_buttons;
  logic [3:0] left_joystick;
  logic [3:0] right_joystick;
  logic       p1_fire;
  logic       p2_fire;
  logic       btn_service;

  always #5 clk_49m = ~clk_49m;

  tutankham_input_conditioner #(
    .TICK_DIV(4), .DEBOUNCE_MS(3), .COIN_MIN_MS(5), .COIN_GAP_MS(2), .FOURWAY(1'b1)
  ) dut (
    .clk_49m(clk_49m), .reset(reset), .pause(pause),
    .raw_coin(raw_coin), .raw_start(raw_start),
    .raw_p1_joy(raw_p1_joy), .raw_p2_joy(raw_p2_joy),
    .raw_p1_fire(raw_p1_fire), .raw_p2_fire(raw_p2_fire), .raw_service(raw_service),
    .coin(coin), .start_buttons(start_buttons),
    .left_joystick(left_joystick), .right_joystick(right_joystick),
    .p1_fire(p1_fire), .p2_fire(p2_fire), .btn_service(btn_service)
  );

  typedef struct {
    int    sel;
    int    val;
    string name;
  } snap_t;

  snap_t snap_q[$];
  int    cw0_q[$];
  int    cw1_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    final_chk = 1'b0;

  function automatic int out_val(input int sel);
    case (sel)
      0:       return int'(coin[0]);
      1:       return int'(coin[1]);
      2:       return int'(start_buttons);
      3:       return int'(left_joystick);
      4:       return int'(right_joystick);
      5:       return int'(p1_fire);
      6:       return int'(p2_fire);
      7:       return int'(btn_service);
      default: return -1;
    endcase
  endfunction

  // Monitor: compares queued snapshots and measures every coin pulse at its falling edge.
  initial begin
    logic [1:0] coin_prev;
    int         hi_cnt [2];
    int         w;
    bit         final_done;
    snap_t      s;
    coin_prev  = 2'b00;
    hi_cnt[0]  = 0;
    hi_cnt[1]  = 0;
    final_done = 1'b0;
    forever begin
      @(negedge clk_49m);
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        checks++;
        if (out_val(s.sel) != s.val) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", s.name, out_val(s.sel), s.val);
        end
      end
      for (int ch = 0; ch < 2; ch++) begin
        if (coin[ch]) begin
          hi_cnt[ch]++;
        end else if (coin_prev[ch]) begin
          if ((ch == 0 && cw0_q.size() == 0) || (ch == 1 && cw1_q.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL coin%0d_unexpected_pulse: got width %0d expected no pulse", ch, hi_cnt[ch]);
          end else begin
            w = (ch == 0) ? cw0_q.pop_front() : cw1_q.pop_front();
            if (w >= 0) begin
              checks++;
              if (hi_cnt[ch] != w) begin
                errors++;
                $display("FAIL coin%0d_width: got %0d expected %0d", ch, hi_cnt[ch], w);
              end
            end
          end
          hi_cnt[ch] = 0;
        end
      end
      coin_prev = coin;
      if (final_chk && !final_done) begin
        final_done = 1'b1;
        checks++;
        if (cw0_q.size() + cw1_q.size() != 0) begin
          errors++;
          $display("FAIL coin_pulses_missing: got %0d outstanding expected 0", cw0_q.size() + cw1_q.size());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_49m);
    #1;
  endtask

  task automatic expect_out(input int sel, input int val, input string name);
    snap_t s;
    s.sel  = sel;
    s.val  = val;
    s.name = name;
    snap_q.push_back(s);
  endtask

  task automatic expect_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      expect_out(i, 0, $sformatf("%s_out%0d", tag, i));
    end
  endtask

  task automatic joy_step(input int player, input logic [3:0] raw, input int exp, input string name);
    if (player == 1) raw_p1_joy = raw;
    else             raw_p2_joy = raw;
    cyc(25);
    expect_out((player == 1) ? 3 : 4, exp, name);
  endtask

  initial begin
    reset = 1'b0; pause = 1'b0; raw_coin = 2'b00; raw_start = 2'b00;
    raw_p1_joy = 4'b0000; raw_p2_joy = 4'b0000;
    raw_p1_fire = 1'b0; raw_p2_fire = 1'b0; raw_service = 1'b0;
    cyc(3);
    expect_all_zero("reset");
    reset = 1'b1;
    cyc(5);

    // An 8-cycle glitch spans at most 2 ticks, short of the 3 needed.
    raw_p1_fire = 1'b1;
    cyc(8);
    raw_p1_fire = 1'b0;
    expect_out(5, 0, "glitch_mid");
    cyc(30);
    expect_out(5, 0, "glitch_after");

    raw_p1_fire = 1'b1;
    cyc(11);
    expect_out(5, 0, "fire_early");
    cyc(8);
    expect_out(5, 1, "fire_latency");
    cyc(21);
    raw_p1_fire = 1'b0;
    cyc(25);
    expect_out(5, 0, "fire_release");

    // Held coin: exactly one 5-tick (20-cycle) pulse; a new press gives a second one.
    cw0_q.push_back(20);
    raw_coin = 2'b01;
    cyc(25);
    expect_out(0, 1, "coin0_high");
    cyc(175);
    expect_out(0, 0, "coin0_held_low");
    raw_coin = 2'b00;
    cyc(50);
    cw0_q.push_back(20);
    raw_coin = 2'b01;
    cyc(60);
    raw_coin = 2'b00;
    cyc(40);

    // 40 paused cycles freeze 10 ticks inside the pulse: 20 + 40 cycles high.
    cw1_q.push_back(60);
    raw_coin = 2'b10;
    cyc(20);
    pause = 1'b1;
    cyc(39);
    expect_out(1, 1, "coin1_paused");
    cyc(1);
    pause = 1'b0;
    cyc(60);
    raw_coin = 2'b00;
    cyc(40);

    joy_step(2, 4'b0001, 1, "p2_up");
    joy_step(2, 4'b0011, 0, "p2_updown_cancel");
    joy_step(2, 4'b1100, 0, "p2_leftright_cancel");
    joy_step(2, 4'b1000, 8, "p2_right");
    joy_step(2, 4'b0000, 0, "p2_idle");

    joy_step(1, 4'b0100, 4, "p1_left");
    joy_step(1, 4'b0101, 1, "p1_left_then_up");
    joy_step(1, 4'b0100, 4, "p1_release_up");
    joy_step(1, 4'b0000, 0, "p1_idle");
    joy_step(1, 4'b1001, 1, "p1_up_right_together");
    joy_step(1, 4'b0000, 0, "p1_idle2");

    raw_start = 2'b10; raw_service = 1'b1; raw_p2_fire = 1'b1;
    cyc(25);
    expect_out(2, 2, "start_p2");
    expect_out(7, 1, "service");
    expect_out(6, 1, "p2_fire");
    raw_start = 2'b00; raw_service = 1'b0; raw_p2_fire = 1'b0;
    cyc(25);
    expect_out(2, 0, "start_release");

    // Reset mid-pulse clears outputs before the next clock edge.
    raw_p1_fire = 1'b1; raw_start = 2'b01; raw_service = 1'b1; raw_p1_joy = 4'b0100;
    cw0_q.push_back(-1);
    raw_coin = 2'b01;
    cyc(24);
    expect_out(0, 1, "coin0_before_reset");
    expect_out(5, 1, "fire_before_reset");
    cyc(1);
    reset = 1'b0;
    expect_all_zero("async_reset");
    cyc(3);
    raw_coin = 2'b00; raw_p1_fire = 1'b0; raw_start = 2'b00; raw_service = 1'b0; raw_p1_joy = 4'b0000;
    cyc(2);
    reset = 1'b1;
    cyc(60);
    expect_out(0, 0, "coin0_no_pulse_after_reset");
    cw0_q.push_back(20);
    raw_coin = 2'b01;
    cyc(60);
    raw_coin = 2'b00;
    cyc(40);
    expect_out(0, 0, "coin0_final");

    final_chk = 1'b1;
    cyc(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
